// File: rtl/cdma_dc_arb_pkg.sv
// Shared constants and helpers for the CDMA DC fifo arbiters.
package cdma_dc_arb_pkg;

   localparam int DC_DW         = 6;
   localparam int DC_FIFO_DEPTH = 128;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/nv_nvdla_cdma_rr_pick.sv
// Rotate-priority one-hot picker: first set bit of eligible scanning from rr_ptr upward, wrapping.
module nv_nvdla_cdma_rr_pick
   import cdma_dc_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = clog2(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [SW-1:0] rr_ptr,
   output logic [N-1:0]  onehot,
   output logic [SW-1:0] index,
   output logic          found
);

   logic [N-1:0] rot;
   logic [SW:0]  sum;

   assign rot   = N'({eligible, eligible} >> rr_ptr);
   assign found = |eligible;

   // Scan high to low so the lowest rotated position wins.
   always_comb begin
      sum = '0;
      for (int j = N-1; j >= 0; j--) begin
         if (rot[j]) sum = {1'b0, rr_ptr} + (SW+1)'(j);
      end
      if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
      index = sum[SW-1:0];
   end

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         onehot[i] = found && (index == SW'(i));
      end
   end

endmodule

// File: rtl/nv_nvdla_cdma_dc_fifo_arb.sv
// Round-robin arbiter with per-requester occupancy quota in front of the shared CDMA DC fifo.
//  state   | meaning
//  ST_ARB  | free to pick the next eligible requester round-robin
//  ST_LOCK | fifo stalled a push; grant held on lk_idx until it is accepted
module nv_nvdla_cdma_dc_fifo_arb
   import cdma_dc_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DW    = DC_DW,
   parameter int QUOTA = 32,
   parameter int SRCW  = clog2(NREQ),
   parameter int CW    = clog2(QUOTA+1)
) (
   input  logic               clk,
   input  logic               reset_,
   input  logic [NREQ-1:0]    req_vld,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_rdy,
   output logic               fifo_wr_req,
   output logic [DW-1:0]      fifo_wr_data,
   input  logic               fifo_wr_ready,
   input  logic               done_vld,
   input  logic [SRCW-1:0]    done_src,
   output logic               quota_err,
   output logic               idle
);

   arb_state_e      state, state_nxt;
   logic [SRCW-1:0] rr_ptr, rr_ptr_nxt, lk_idx, lk_idx_nxt, pick_idx, gnt_idx;
   logic [NREQ-1:0] eligible, pick_oh, lk_oh, push_vec, done_vec;
   logic [CW-1:0]   cnt [NREQ];
   logic            pick_found, push, err_q, err_set, src_bad, all_zero;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req_vld[i] && (cnt[i] < CW'(QUOTA));
         lk_oh[i]    = (lk_idx == SRCW'(i));
         done_vec[i] = done_vld && ({1'b0, done_src} == (SRCW+1)'(i));
      end
   end

   nv_nvdla_cdma_rr_pick #(.N(NREQ), .SW(SRCW)) u_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .onehot   (pick_oh),
      .index    (pick_idx),
      .found    (pick_found)
   );

   // Outputs are gated by reset_ so they read quiet while reset is held, not only after the edge.
   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      lk_idx_nxt  = lk_idx;
      req_rdy     = '0;
      gnt_idx     = (state == ST_LOCK) ? lk_idx : pick_idx;
      fifo_wr_req = reset_ && ((state == ST_LOCK) || pick_found);
      push        = fifo_wr_req && fifo_wr_ready;
      if (push) begin
         req_rdy   = (state == ST_LOCK) ? lk_oh : pick_oh;
         state_nxt = ST_ARB;
         if (gnt_idx == SRCW'(NREQ-1)) rr_ptr_nxt = '0;
         else                          rr_ptr_nxt = gnt_idx + SRCW'(1);
      end else if (fifo_wr_req) begin
         state_nxt  = ST_LOCK;
         lk_idx_nxt = gnt_idx;
      end
   end

   always_comb begin
      fifo_wr_data = '0;
      if (fifo_wr_req) begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == SRCW'(i)) fifo_wr_data = req_data[i*DW +: DW];
         end
      end
   end

   assign push_vec = req_rdy;
   assign src_bad  = done_vld && ({1'b0, done_src} >= (SRCW+1)'(NREQ));

   always_comb begin
      err_set  = src_bad;
      all_zero = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (done_vec[i] && !push_vec[i] && (cnt[i] == '0)) err_set = 1'b1;
         if (cnt[i] != '0) all_zero = 1'b0;
      end
   end

   assign quota_err = reset_ && err_q;
   assign idle      = !reset_ || (all_zero && !(|req_vld));

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state  <= ST_ARB;
         rr_ptr <= '0;
         lk_idx <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         lk_idx <= lk_idx_nxt;
         if (err_set) err_q <= 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (push_vec[i] && !done_vec[i])
               cnt[i] <= cnt[i] + CW'(1);
            else if (done_vec[i] && !push_vec[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nv_nvdla_cdma_dc_fifo_arb.sv
// Bench for the DC fifo arbiter: directed scenarios plus a randomized fill run against a cycle model.
module tb_nv_nvdla_cdma_dc_fifo_arb;

   localparam int NREQ  = 4;
   localparam int DW    = 6;
   localparam int QUOTA = 32;

   logic             clk = 1'b0;
   logic             reset_;
   logic [NREQ-1:0]  req_vld;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]  req_rdy;
   logic             fifo_wr_req;
   logic [DW-1:0]    fifo_wr_data;
   logic             fifo_wr_ready;
   logic             done_vld;
   logic [1:0]       done_src;
   logic             quota_err;
   logic             idle;
   logic [DW-1:0]    rd [NREQ];

   assign req_data = {rd[3], rd[2], rd[1], rd[0]};
   always #5 clk = ~clk;

   nv_nvdla_cdma_dc_fifo_arb dut (
      .clk           (clk),
      .reset_        (reset_),
      .req_vld       (req_vld),
      .req_data      (req_data),
      .req_rdy       (req_rdy),
      .fifo_wr_req   (fifo_wr_req),
      .fifo_wr_data  (fifo_wr_data),
      .fifo_wr_ready (fifo_wr_ready),
      .done_vld      (done_vld),
      .done_src      (done_src),
      .quota_err     (quota_err),
      .idle          (idle)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: occupancy per source, rotating start point, held grant.
   int  m_cnt [NREQ];
   int  m_ptr;
   bit  m_lock;
   int  m_lk;
   bit  m_err;

   logic [NREQ-1:0] s_rdy;
   logic            s_wr, s_err, s_idle;
   logic [DW-1:0]   s_data;

   bit            sb_on;
   int            fq_src [$];
   logic [DW-1:0] fq_data [$];
   int            sent_src [$];
   logic [DW-1:0] sent_data [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      int g, s, src;
      bit wr, push, all0, hit;
      logic [NREQ-1:0] e_rdy;
      @(negedge clk);
      s_rdy  = req_rdy;
      s_wr   = fifo_wr_req;
      s_data = fifo_wr_data;
      s_err  = quota_err;
      s_idle = idle;
      if (!reset_) begin
         chk("rst_wr_req", fifo_wr_req, 0);
         chk("rst_rdy", req_rdy, 0);
         chk("rst_idle", idle, 1);
         chk("rst_err", quota_err, 0);
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
         m_ptr = 0; m_lock = 0; m_lk = 0; m_err = 0;
      end else begin
         if (m_lock) chk("proto_hold", req_vld[m_lk], 1);
         g = -1;
         if (m_lock) g = m_lk;
         else begin
            for (int k = 0; k < NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (g < 0 && req_vld[idx] && m_cnt[idx] < QUOTA) g = idx;
            end
         end
         wr    = (g >= 0);
         push  = wr && fifo_wr_ready;
         e_rdy = push ? NREQ'(1 << g) : '0;
         all0  = 1;
         for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) all0 = 0;
         chk("wr_req", fifo_wr_req, wr);
         chk("rdy", req_rdy, e_rdy);
         if (wr) chk("wr_data", fifo_wr_data, rd[g]);
         chk("idle", idle, all0 && (req_vld == 0));
         chk("quota_err", quota_err, m_err);

         if (sb_on) begin
            if (done_vld && fq_src.size() > 0) begin
               int ps;
               logic [DW-1:0] pd;
               ps  = fq_src.pop_front();
               pd  = fq_data.pop_front();
               hit = 0;
               for (int j = 0; j < sent_src.size() && !hit; j++) begin
                  if (sent_src[j] == ps) begin
                     chk("sb_order", pd, sent_data[j]);
                     sent_src.delete(j);
                     sent_data.delete(j);
                     hit = 1;
                  end
               end
               if (!hit) chk("sb_found", 0, 1);
            end
            if (fifo_wr_req && fifo_wr_ready) begin
               src = -1;
               for (int i = 0; i < NREQ; i++) if (req_rdy[i]) src = i;
               if (src < 0) chk("sb_src", 0, 1);
               else begin
                  fq_src.push_back(src);
                  fq_data.push_back(fifo_wr_data);
                  sent_src.push_back(src);
                  sent_data.push_back(rd[src]);
               end
            end
         end

         s = int'(done_src);
         if (done_vld && !(push && g == s)) begin
            if (m_cnt[s] == 0) m_err = 1;
            else               m_cnt[s]--;
         end
         if (push && !(done_vld && g == s)) m_cnt[g]++;
         if (push) begin
            m_ptr  = (g + 1) % NREQ;
            m_lock = 0;
         end else if (wr) begin
            m_lock = 1;
            m_lk   = g;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_ = 1'b0;
      cyc();
      cyc();
      reset_ = 1'b1;
   endtask

   task automatic stim(input bit drain);
      for (int i = 0; i < NREQ; i++) begin
         if (req_vld[i] && s_rdy[i]) req_vld[i] = 1'b0;
         if (!req_vld[i] && !drain && $urandom_range(0, 99) < 50) begin
            req_vld[i] = 1'b1;
            rd[i]      = DW'($urandom);
         end
      end
      fifo_wr_ready = (drain || $urandom_range(0, 99) < 70) && (fq_src.size() < 128);
      done_vld      = (fq_src.size() > 0) && (drain || $urandom_range(0, 99) < 40);
      done_src      = done_vld ? 2'(fq_src[0]) : 2'd0;
   endtask

   initial begin
      int n;
      bit fin;
      reset_        = 1'b0;
      req_vld       = '0;
      fifo_wr_ready = 1'b0;
      done_vld      = 1'b0;
      done_src      = '0;
      sb_on         = 0;
      for (int i = 0; i < NREQ; i++) rd[i] = DW'(5 * i + 7);

      // reset with all requesters asserting, then round-robin fairness
      req_vld = '1;
      reset_  = 1'b0;
      cyc();
      chk("t1_wr_req", s_wr, 0);
      chk("t1_idle", s_idle, 1);
      cyc();
      reset_        = 1'b1;
      fifo_wr_ready = 1'b1;
      for (int k = 0; k < 32; k++) begin
         cyc();
         chk("t2_grant", s_rdy, 1 << (k % NREQ));
      end

      // stall holds the grant and its data
      req_vld = '0;
      do_reset();
      rd[1] = 6'h15;
      rd[2] = 6'h2a;
      req_vld = 4'b0110;
      fifo_wr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t3_stall_data", s_data, 6'h15);
         chk("t3_stall_rdy", s_rdy, 0);
      end
      fifo_wr_ready = 1'b1;
      cyc();
      chk("t3_accept", s_rdy, 4'b0010);
      req_vld = 4'b0100;
      cyc();
      chk("t3_next", s_rdy, 4'b0100);

      // quota on a single source
      req_vld = '0;
      do_reset();
      req_vld = 4'b0100;
      n = 0;
      repeat (40) begin
         cyc();
         if (s_rdy[2]) n++;
      end
      chk("t4_pushes", n, QUOTA);
      chk("t4_wr_req_off", s_wr, 0);
      done_vld = 1'b1;
      done_src = 2'd2;
      n = 0;
      cyc();
      if (s_rdy[2]) n++;
      done_vld = 1'b0;
      repeat (6) begin
         cyc();
         if (s_rdy[2]) n++;
      end
      chk("t4_credit", n, 1);

      // simultaneous push/done, then underflow error
      req_vld = '0;
      do_reset();
      req_vld = 4'b1000;
      repeat (5) cyc();
      done_vld = 1'b1;
      done_src = 2'd3;
      cyc();
      chk("t5_push_done", s_rdy, 4'b1000);
      done_vld = 1'b0;
      n = 0;
      repeat (35) begin
         cyc();
         if (s_rdy[3]) n++;
      end
      chk("t5_remaining", n, QUOTA - 5);
      req_vld  = '0;
      done_vld = 1'b1;
      done_src = 2'd0;
      cyc();
      done_vld = 1'b0;
      cyc();
      chk("t5_err_set", s_err, 1);
      repeat (10) cyc();
      chk("t5_err_sticky", s_err, 1);
      do_reset();
      cyc();
      chk("t5_err_clr", s_err, 0);

      // random fill with a real fifo and in-order scoreboard
      do_reset();
      sb_on = 1;
      s_rdy = '0;
      repeat (3000) begin
         stim(0);
         cyc();
      end
      fin = 0;
      for (int c = 0; c < 3000 && !fin; c++) begin
         stim(1);
         if (req_vld == 0 && fq_src.size() == 0) fin = 1;
         else cyc();
      end
      chk("t6_drain", fin, 1);
      fifo_wr_ready = 1'b0;
      done_vld      = 1'b0;
      cyc();
      chk("t6_idle", s_idle, 1);
      chk("t6_leftover", sent_src.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
